// File: rtl/imem_loader_pkg.sv
// ============================================================================
// Module : imem_loader_pkg
// Brief  : Shared state encodings and framing constants for the imem loader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package imem_loader_pkg;

    typedef enum logic [2:0] {
        LEN0 = 3'd0,
        LEN1 = 3'd1,
        DATA = 3'd2,
        DONE = 3'd3,
        CHK  = 3'd4
    } state_t;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

endpackage

`default_nettype wire

// File: rtl/imem_loader_byte_word_assembler.sv
// ============================================================================
// Module : byte_word_assembler
// Brief  : Little-endian byte-to-word shifter with byte counter and a
//          registered one-cycle word_done pulse.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module byte_word_assembler
    import imem_loader_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [7:0]            i_byte,
    output logic [BYTE_CNT_W-1:0] o_byte_cnt,
    output logic [DATA_W-1:0]     o_word,
    output logic                  o_word_done
);

    logic [DATA_W-1:0]     r_shift;
    logic [DATA_W-1:0]     r_word;
    logic [BYTE_CNT_W-1:0] r_cnt;
    logic                  r_word_done;
    logic [DATA_W-1:0]     w_shift_next;

    // New bytes enter at the top so the first byte ends up in [7:0].
    assign w_shift_next = {i_byte, r_shift[DATA_W-1:8]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift     <= '0;
            r_word      <= '0;
            r_cnt       <= '0;
            r_word_done <= 1'b0;
        end else begin
            r_word_done <= 1'b0;
            if (i_valid) begin
                r_shift <= w_shift_next;
                r_cnt   <= r_cnt + 1'b1;
                if (r_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1)) begin
                    r_word      <= w_shift_next;
                    r_word_done <= 1'b1;
                end
            end
        end
    end

    assign o_byte_cnt  = r_cnt;
    assign o_word      = r_word;
    assign o_word_done = r_word_done;

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module : imem_loader
// Brief  : Byte-serial instruction memory loader; releases core_run once the
//          framed program is written. Optional IMEM_LOADER_CHECKSUM_EN adds a
//          trailing XOR checksum byte.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_run,
    output logic              err
);

    localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_in_ready;
    logic                  r_core_run;
    logic                  r_err;
    logic [15:0]           r_len;
    logic [ADDR_W-1:0]     r_word_idx;
    logic [ADDR_W-1:0]     r_waddr;
    logic                  w_xfer;
    logic                  w_set_err;
    logic                  w_last_byte;
    logic                  w_last_word;
    logic [15:0]           w_len_full;
    logic [BYTE_CNT_W-1:0] w_byte_cnt;
    logic [DATA_W-1:0]     w_word;
    logic                  w_word_done;

    assign w_xfer      = in_valid && r_in_ready;
    assign w_len_full  = {in_data, r_len[7:0]};
    assign w_last_byte = w_xfer && (r_state == DATA) &&
                         (w_byte_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));
    assign w_last_word = (32'(r_word_idx) + 32'd1) == 32'(r_len);

    byte_word_assembler #(
        .DATA_W (DATA_W)
    ) u_asm (
        .clk         (clk),
        .rst         (reset),
        .i_valid     (w_xfer && (r_state == DATA)),
        .i_byte      (in_data),
        .o_byte_cnt  (w_byte_cnt),
        .o_word      (w_word),
        .o_word_done (w_word_done)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] r_csum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_csum <= '0;
        end else if (w_xfer && (r_state == DATA)) begin
            r_csum <= r_csum ^ in_data;
        end
    end
`endif

    always_comb begin
        w_next_state = r_state;
        w_set_err    = 1'b0;
        case (r_state)
            LEN0: begin
                if (w_xfer) w_next_state = LEN1;
            end
            LEN1: begin
                if (w_xfer) begin
                    if (w_len_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        w_next_state = CHK;
`else
                        w_next_state = DONE;
`endif
                    end else if (32'(w_len_full) > DEPTH) begin
                        // Oversized program: refuse it outright, nothing is written.
                        w_set_err    = 1'b1;
                        w_next_state = DONE;
                    end else begin
                        w_next_state = DATA;
                    end
                end
            end
            DATA: begin
                if (w_last_byte && w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_next_state = CHK;
`else
                    w_next_state = DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                if (w_xfer) begin
                    w_next_state = DONE;
                    w_set_err    = (in_data != r_csum);
                end
            end
`endif
            DONE: begin
                w_next_state = DONE;
            end
            default: begin
                w_next_state = LEN0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= LEN0;
            r_in_ready <= 1'b0;
            r_core_run <= 1'b0;
            r_err      <= 1'b0;
            r_len      <= '0;
            r_word_idx <= '0;
            r_waddr    <= '0;
        end else begin
            r_state    <= w_next_state;
            // Registered from the next state so ready drops with the final accepted byte.
            r_in_ready <= (w_next_state != DONE);
            r_core_run <= (r_state == DONE) && !r_err;
            if (w_set_err) r_err <= 1'b1;
            if (w_xfer && (r_state == LEN0)) r_len[7:0]  <= in_data;
            if (w_xfer && (r_state == LEN1)) r_len[15:8] <= in_data;
            if (w_last_byte) begin
                r_waddr <= r_word_idx;
                if (!w_last_word) r_word_idx <= r_word_idx + 1'b1;
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign imem_we    = w_word_done;
    assign imem_waddr = r_waddr;
    assign imem_wdata = w_word;
    assign core_run   = r_core_run;
    assign err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module : tb_imem_loader
// Brief  : Scoreboard bench for imem_loader with randomized framed loads.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              core_run;
    logic              err;

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .core_run   (core_run),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        longint            cyc;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] fw[$];
    longint      cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic        prev_we = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every write strobe is matched against the oldest expected write.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (prev_we) chk("we_back_to_back", {31'd0, prev_we}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_we", {31'd0, imem_we}, 32'd0);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("waddr", 32'(imem_waddr), 32'(w.addr));
                chk("wdata", imem_wdata, w.data);
                chk("we_latency", cyc[31:0], w.cyc[31:0]);
            end
        end
        prev_we = (imem_we === 1'b1);
    end

    // gap_mode: 0 back-to-back, 1 one idle cycle before each byte, 2 random idles.
    task automatic send_byte(input logic [7:0] b, input int gap_mode);
        int  t;
        bit  acc;
        int  gap;
        gap = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        t   = 0;
        acc = 1'b0;
        while (!acc && t < 20) begin
            @(negedge clk);
            acc = (in_ready === 1'b1);
            @(posedge clk); #1;
            t++;
        end
        if (!acc) chk("byte_accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic do_reset_check();
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
        chk("rst_waddr", 32'(imem_waddr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_core_run", {31'd0, core_run}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Sends one full frame built from fw[] and checks the post-load status.
    task automatic run_frame(input int n, input int gap_mode, input bit bad_csum);
        logic [15:0] nn;
        logic [7:0]  b;
        logic [7:0]  csum;
        bit          exp_err;
        nn      = 16'(n);
        csum    = 8'h00;
        exp_err = (n > DEPTH);
        send_byte(nn[7:0], gap_mode);
        send_byte(nn[15:8], gap_mode);
        if (!exp_err) begin
            for (int i = 0; i < n; i++) begin
                for (int j = 0; j < 4; j++) begin
                    b    = fw[i][8*j +: 8];
                    csum = csum ^ b;
                    send_byte(b, gap_mode);
                    if (j == 3) exp_q.push_back('{addr: i[ADDR_W-1:0], data: fw[i], cyc: cyc});
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (bad_csum) csum = csum ^ 8'h01;
            send_byte(csum, gap_mode);
            exp_err = bad_csum;
`endif
        end
        @(negedge clk);
        chk("core_run_early", {31'd0, core_run}, 32'd0);
        @(negedge clk);
        chk("core_run", {31'd0, core_run}, {31'd0, !exp_err});
        chk("err", {31'd0, err}, {31'd0, exp_err});
        chk("in_ready_done", {31'd0, in_ready}, 32'd0);
        repeat (3) @(negedge clk);
        chk("core_run_hold", {31'd0, core_run}, {31'd0, !exp_err});
        chk("pending_writes", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic fill_random(input int n);
        fw.delete();
        for (int i = 0; i < n; i++) fw.push_back($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset_check();

        fw.delete();
        fw.push_back(32'h00100013);
        fw.push_back(32'h00628533);
        run_frame(2, 0, 1'b0);

        do_reset_check();
        run_frame(2, 1, 1'b0);

        do_reset_check();
        run_frame(0, 0, 1'b0);

        // Oversized program, then confirm offered bytes are refused.
        do_reset_check();
        run_frame(DEPTH + 1, 0, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (4) begin
            @(negedge clk);
            chk("err_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;

        // Reset two bytes into word 1, then a fresh single-word frame.
        do_reset_check();
        fill_random(2);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        for (int j = 0; j < 4; j++) send_byte(fw[0][8*j +: 8], 0);
        exp_q.push_back('{addr: '0, data: fw[0], cyc: cyc});
        send_byte(fw[1][7:0], 0);
        send_byte(fw[1][15:8], 0);
        do_reset_check();
        chk("midload_pending", 32'(exp_q.size()), 32'd0);
        fill_random(1);
        run_frame(1, 0, 1'b0);

        fw.delete();
        fw.push_back(32'hAABBCCDD);
        do_reset_check();
        run_frame(1, 0, 1'b0);
        do_reset_check();
        run_frame(1, 0, 1'b1);

        do_reset_check();
        fill_random(DEPTH);
        run_frame(DEPTH, 0, 1'b0);

        for (int k = 0; k < 8; k++) begin
            int n;
            n = int'($urandom_range(1, 6));
            do_reset_check();
            fill_random(n);
            run_frame(n, 2, 1'($urandom_range(0, 1)));
        end

        do_reset_check();
        run_frame(16'hFFFF, 2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
